// File: rtl/pc_updater_pkg.sv
// Shared definitions for the program-counter update block.
// Holds the default PC width and the 3-bit branch condition codes.
package pc_updater_pkg;

    localparam int ADDR_W = 16;

    typedef enum logic [2:0] {
        NE = 3'b000,
        EQ = 3'b001,
        GT = 3'b010,
        LT = 3'b011,
        GE = 3'b100,
        LE = 3'b101,
        OV = 3'b110,
        UN = 3'b111
    } cond_e;

endpackage

// File: rtl/pc_updater_branch_cond_eval.sv
// Purpose: decode a 3-bit condition code against the Z/N/V flags into a taken bit.
// Latency: purely combinational.
// Backpressure: none.
module branch_cond_eval
    import pc_updater_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       Z,
    input  logic       N,
    input  logic       V,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            NE:      taken = ~Z;
            EQ:      taken = Z;
            GT:      taken = ~Z & ~N;
            LT:      taken = N;
            GE:      taken = Z | ~N;
            LE:      taken = Z | N;
            OV:      taken = V;
            // Constant so an unconditional jump never picks up X from the flags.
            UN:      taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_updater.sv
// Purpose: program counter register with halt, conditional branch and PC+2 sequencing.
// Latency: OutAddr is registered (one edge after inputs); PCSOut is OutAddr+2 combinationally.
// Backpressure: none; hlt freezes the PC in place, rst overrides everything.
module pc_updater #(
    parameter int ADDR_W = pc_updater_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              AddrSrc,
    input  logic [ADDR_W-1:0] InAddrImm,
    input  logic [ADDR_W-1:0] InAddrReg,
    input  logic              branch,
    input  logic [2:0]        cond,
    input  logic              Z,
    input  logic              N,
    input  logic              V,
    input  logic              hlt,
    output logic [ADDR_W-1:0] OutAddr,
    output logic [ADDR_W-1:0] PCSOut
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_plus2;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_next;
    logic              taken;

    branch_cond_eval u_cond (
        .cond  (cond),
        .Z     (Z),
        .N     (N),
        .V     (V),
        .taken (taken)
    );

    // Adders are sized to ADDR_W so carries drop out and addresses wrap.
    assign pc_plus2 = pc_q + ADDR_W'(2);
    assign target   = AddrSrc ? (pc_plus2 + InAddrImm) : InAddrReg;

    always_comb begin
        pc_next = pc_plus2;
        if (hlt)
            pc_next = pc_q;
        else if (branch && taken)
            pc_next = target;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc_q <= '0;
        else
            pc_q <= pc_next;
    end

    assign OutAddr = pc_q;
    assign PCSOut  = pc_q + ADDR_W'(2);

endmodule

// File: tb/tb_pc_updater.sv
// Directed bench for pc_updater: expected PCs are queued when a step is driven and
// popped after the clock edge that should produce them.
module tb_pc_updater;

    logic        clk;
    logic        rst;
    logic        AddrSrc;
    logic [15:0] InAddrImm;
    logic [15:0] InAddrReg;
    logic        branch;
    logic [2:0]  cond;
    logic        Z;
    logic        N;
    logic        V;
    logic        hlt;
    logic [15:0] OutAddr;
    logic [15:0] PCSOut;

    int passed = 0;
    int total  = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_pc;

    pc_updater #(.ADDR_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .AddrSrc   (AddrSrc),
        .InAddrImm (InAddrImm),
        .InAddrReg (InAddrReg),
        .branch    (branch),
        .cond      (cond),
        .Z         (Z),
        .N         (N),
        .V         (V),
        .hlt       (hlt),
        .OutAddr   (OutAddr),
        .PCSOut    (PCSOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected PC, then compare after the edge.
    task automatic step(input string tag, input logic r, input logic h, input logic br,
                        input logic [2:0] c, input logic z, input logic n, input logic v,
                        input logic src, input logic [15:0] imm, input logic [15:0] rg,
                        input logic [15:0] exp);
        logic [15:0] e;
        rst = r; hlt = h; branch = br; cond = c; Z = z; N = n; V = v;
        AddrSrc = src; InAddrImm = imm; InAddrReg = rg;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        total++;
        assert (sb.size() == 1) begin
            passed++;
        end else begin
            $error("FAIL %s_queue: observed %0d expected 1", tag, sb.size());
        end
        e = sb.pop_front();
        check({tag, "_pc"}, OutAddr, e);
        check({tag, "_pcs"}, PCSOut, e + 16'd2);
    endtask

    typedef struct {
        logic [2:0] c;
        logic       z;
        logic       n;
        logic       v;
        logic       tk;
    } cond_row_t;

    cond_row_t rows[$];

    initial begin
        rst = 1'b1; hlt = 1'b0; branch = 1'b0; cond = 3'b000;
        Z = 1'b0; N = 1'b0; V = 1'b0; AddrSrc = 1'b0;
        InAddrImm = 16'h0; InAddrReg = 16'h0;
        #2;

        // Reset, then first free-running edge
        step("reset",   1, 0, 0, 3'b000, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0000);
        step("first",   0, 0, 0, 3'b000, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0002);
        step("ne_not",  0, 0, 1, 3'b000, 1, 0, 0, 0, 16'h0, 16'd10, 16'h0004);
        step("ne_tk",   0, 0, 1, 3'b000, 0, 0, 0, 0, 16'h0, 16'd10, 16'd10);

        // All condition codes, taken and not taken
        rows = '{
            '{3'b000, 0, 0, 0, 1}, '{3'b000, 1, 0, 0, 0},
            '{3'b001, 1, 0, 0, 1}, '{3'b001, 0, 0, 0, 0},
            '{3'b010, 0, 0, 0, 1}, '{3'b010, 1, 0, 0, 0}, '{3'b010, 0, 1, 0, 0},
            '{3'b011, 0, 1, 0, 1}, '{3'b011, 0, 0, 0, 0},
            '{3'b100, 0, 1, 0, 0}, '{3'b100, 0, 0, 0, 1}, '{3'b100, 1, 0, 0, 1},
            '{3'b100, 1, 1, 0, 1},
            '{3'b101, 1, 0, 0, 1}, '{3'b101, 0, 1, 0, 1}, '{3'b101, 0, 0, 0, 0},
            '{3'b110, 0, 0, 1, 1}, '{3'b110, 1, 1, 0, 0},
            '{3'b111, 0, 0, 0, 1}, '{3'b111, 1, 1, 1, 1}
        };
        exp_pc = 16'd10;
        foreach (rows[i]) begin
            logic [15:0] tgt;
            tgt = 16'h0100 + 16'(i * 16);
            exp_pc = rows[i].tk ? tgt : exp_pc + 16'd2;
            step($sformatf("cond%0d_row%0d", rows[i].c, i), 0, 0, 1, rows[i].c,
                 rows[i].z, rows[i].n, rows[i].v, 0, 16'h0, tgt, exp_pc);
        end

        // branch=0 ignores condition and targets
        exp_pc = exp_pc + 16'd2;
        step("nobranch", 0, 0, 0, 3'b111, 1, 1, 1, 1, 16'h4000, 16'h7777, exp_pc);

        // Unconditional with X flags
        step("un_x0", 0, 0, 1, 3'b111, 1'bx, 1'bx, 1'bx, 0, 16'h0, 16'd100, 16'd100);
        step("un_x1", 0, 0, 1, 3'b111, 1'bx, 1'bx, 1'bx, 0, 16'h0, 16'd100, 16'd100);

        // Halt beats branch, then resume
        step("halt",    0, 1, 1, 3'b111, 0, 0, 0, 0, 16'h0, 16'd200, 16'd100);
        step("halt2",   0, 1, 0, 3'b000, 0, 0, 0, 0, 16'h0, 16'd200, 16'd100);
        step("resume",  0, 0, 0, 3'b111, 0, 0, 0, 0, 16'h0, 16'd200, 16'd102);

        // Immediate target with wrap, and PC+2 wrap
        step("to10",    0, 0, 1, 3'b111, 0, 0, 0, 0, 16'h0, 16'h0010, 16'h0010);
        step("imm_wrap",0, 0, 1, 3'b111, 0, 0, 0, 1, 16'hFFF0, 16'h5555, 16'h0002);
        step("imm_pos", 0, 0, 1, 3'b001, 1, 0, 0, 1, 16'h0020, 16'h5555, 16'h0024);
        step("toFFFE",  0, 0, 1, 3'b111, 0, 0, 0, 0, 16'h0, 16'hFFFE, 16'hFFFE);
        step("pc_wrap", 0, 0, 0, 3'b000, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0000);

        // Reset overrides halt and taken branch
        step("to300",   0, 0, 1, 3'b111, 0, 0, 0, 0, 16'h0, 16'd300, 16'd300);
        step("rst_mid", 1, 1, 1, 3'b111, 0, 0, 0, 0, 16'h0, 16'd400, 16'h0000);
        step("post_rst",0, 0, 0, 3'b000, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0002);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_updater.md
PC_UPDATER -- requirements
Module: pc_updater

Interface
REQ-001 Parameter ADDR_W, default 16: width of PC, targets and outputs; all values below assume 16.
REQ-002 Ports use one clock and a synchronous, active-high reset, named as the codebase does:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- AddrSrc  in  1  target select: 0 = InAddrReg, 1 = InAddrImm offset.
- InAddrImm  in  16  byte offset, already sign-extended and shifted; added to PC+2.
- InAddrReg  in  16  absolute register target address.
- branch  in  1  current instruction is a branch/jump.
- cond  in  3  branch condition code.
- Z  in  1  zero flag.
- N  in  1  negative flag.
- V  in  1  overflow flag.
- hlt  in  1  halt: freeze the PC.
- OutAddr  out  16  current PC (registered).
- PCSOut  out  16  OutAddr + 2, combinational (return address for PCS).

Function
REQ-003 A 16-bit PC register SHALL drive OutAddr directly, with no combinational path from the inputs to OutAddr.
REQ-004 Next-PC priority at each rising edge: rst -> 0; else hlt -> hold; else (branch & taken) -> target; else PC+2.
REQ-005 PC+2 and PC+2+InAddrImm SHALL wrap modulo 2^16 (0xFFFE+2 = 0x0000); carries are discarded.
REQ-006 Target SHALL be InAddrReg when AddrSrc=0, and (PC+2)+InAddrImm when AddrSrc=1.
REQ-007 taken SHALL be decoded from cond as follows:
- 000 NE: ~Z
- 001 EQ: Z
- 010 GT: ~Z & ~N
- 011 LT: N
- 100 GE: Z | ~N
- 101 LE: Z | N
- 110 OV: V
- 111 UN: 1
REQ-008 For cond=111, taken SHALL be exactly 1 and SHALL NOT depend on Z, N or V, including when they are X in simulation.
REQ-009 When branch=0, cond, flags and targets SHALL be ignored.
REQ-010 hlt=1 with a taken branch SHALL hold the PC; halt beats branch.
REQ-011 Deasserting hlt SHALL resume normal sequencing on the next edge.
REQ-012 PCSOut SHALL always equal OutAddr+2 (mod 2^16), including while halted.

Reset
REQ-013 While rst=1 at a rising edge, the PC SHALL load 0x0000, overriding hlt and branch.
REQ-014 After reset, OutAddr=0x0000 and PCSOut=0x0002.
REQ-015 The first edge with rst=0 SHALL produce OutAddr=0x0002 when no branch and no halt are asserted.
REQ-016 The block SHALL have no other state to reset.

Structure
REQ-017 A shared package SHALL hold the 3-bit condition-code constants (NE, EQ, GT, LT, GE, LE, OV, UN) and ADDR_W.
REQ-018 One sub-module, branch_cond_eval (inputs cond, Z, N, V; output taken), SHALL implement REQ-007 and REQ-008 as pure combinational logic.
REQ-019 The top level SHALL contain the PC register, the two adders and the next-PC mux.

Verification
REQ-020 Reset then sequence: rst=1 for one edge -> OutAddr=0, PCSOut=2; next edge with branch=0 -> OutAddr=2.
REQ-021 Each condition taken and not taken, with AddrSrc=0, from PC=2:
- cond=000, Z=1 -> PC 4; then Z=0, InAddrReg=10 -> PC 10.
- Cover all 8 codes with both outcomes per REQ-007, e.g. cond=100: Z=0,N=1 -> +2; Z=0,N=0 -> jump; Z=1,N=0 -> jump.
REQ-022 Unconditional with unknown flags: cond=111, Z=N=V=X, InAddrReg=100 -> PC=100 on every edge.
REQ-023 Halt priority: PC=100, hlt=1, branch=1, cond=111 -> PC stays 100; then hlt=0, branch=0 -> PC 102.
REQ-024 Immediate target and wrap:
- PC=0x0010, AddrSrc=1, InAddrImm=0xFFF0, cond=111 -> PC 0x0002.
- PC=0xFFFE, branch=0 -> PC 0x0000.
REQ-025 Reset mid-operation: rst=1 together with hlt=1 and a taken branch -> PC 0x0000.
